// File: rtl/sid_envelope_pkg.sv
// Shared SID types plus the envelope rate and exponential-decay period helpers.
package sid;

  typedef logic [3:0]  reg4_t;
  typedef logic [7:0]  reg8_t;
  typedef logic [14:0] reg15_t;
  typedef logic [4:0]  exp_period_t;

  typedef struct packed {
    logic  gate;
    reg4_t attack;
    reg4_t decay;
    reg4_t sustain;
    reg4_t release_;
  } envelope_reg_t;

  typedef enum logic [1:0] {
    ATTACK        = 2'd0,
    DECAY_SUSTAIN = 2'd1,
    RELEASE       = 2'd2
  } envelope_state_e;

  function automatic reg15_t rate_period(input reg4_t idx);
    case (idx)
      4'd0:    rate_period = 15'd9;
      4'd1:    rate_period = 15'd32;
      4'd2:    rate_period = 15'd63;
      4'd3:    rate_period = 15'd95;
      4'd4:    rate_period = 15'd149;
      4'd5:    rate_period = 15'd220;
      4'd6:    rate_period = 15'd267;
      4'd7:    rate_period = 15'd313;
      4'd8:    rate_period = 15'd392;
      4'd9:    rate_period = 15'd977;
      4'd10:   rate_period = 15'd1954;
      4'd11:   rate_period = 15'd3126;
      4'd12:   rate_period = 15'd3907;
      4'd13:   rate_period = 15'd11720;
      4'd14:   rate_period = 15'd19532;
      default: rate_period = 15'd31251;
    endcase
  endfunction

  // The period only moves at these breakpoints, so it has hysteresis between them.
  function automatic exp_period_t exp_period_update(input reg8_t env, input exp_period_t cur);
    case (env)
      8'hFF:   exp_period_update = 5'd1;
      8'h5D:   exp_period_update = 5'd2;
      8'h36:   exp_period_update = 5'd4;
      8'h1A:   exp_period_update = 5'd8;
      8'h0E:   exp_period_update = 5'd16;
      8'h06:   exp_period_update = 5'd30;
      8'h00:   exp_period_update = 5'd1;
      default: exp_period_update = cur;
    endcase
  endfunction

endpackage

// File: rtl/sid_envelope_if.sv
// Bundle of the per-voice envelope strobe, register image and envelope readback.
interface sid_envelope_if;
  import sid::*;

  logic          phi2;
  envelope_reg_t regs;
  reg8_t         envelope;

  modport master (output phi2, output regs, input envelope);
  modport slave  (input phi2, input regs, output envelope);
endinterface

// File: rtl/sid_envelope.sv
// SID ADSR envelope generator for one voice; all state advances on the phi2 strobe.
module sid_envelope
  import sid::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          phi2,
  input  envelope_reg_t regs,
  output reg8_t         envelope
);

  envelope_state_e state_q, state_d;
  reg8_t           env_q, env_d;
  reg15_t          rate_cnt_q, rate_cnt_d;
  exp_period_t     exp_cnt_q, exp_cnt_d;
  exp_period_t     exp_per_q, exp_per_d;
  logic            hold_zero_q, hold_zero_d;
  logic            gate_prev_q, gate_prev_d;
  logic            gate_armed_q, gate_armed_d;

  reg15_t          period_s;
  logic            rate_event_s;
  logic            gate_rise_s;
  logic            gate_fall_s;

  assign envelope = env_q;

  // Next-state: gate edges, rate divider, exponential divider and envelope step.
  always_comb begin
    state_d      = state_q;
    env_d        = env_q;
    rate_cnt_d   = rate_cnt_q;
    exp_cnt_d    = exp_cnt_q;
    exp_per_d    = exp_per_q;
    hold_zero_d  = hold_zero_q;
    gate_prev_d  = gate_prev_q;
    gate_armed_d = gate_armed_q;
    period_s     = 15'd0;
    rate_event_s = 1'b0;
    // A gate already high when reset lifts is not an edge; it must be seen low first.
    gate_rise_s  = regs.gate & ~gate_prev_q & gate_armed_q;
    gate_fall_s  = ~regs.gate & gate_prev_q;

    if (phi2) begin
      gate_prev_d  = regs.gate;
      gate_armed_d = gate_armed_q | ~regs.gate;

      if (gate_rise_s) begin
        state_d     = ATTACK;
        hold_zero_d = 1'b0;
      end else if (gate_fall_s) begin
        state_d = RELEASE;
      end else begin
        state_d = state_q;
      end

      case (state_d)
        ATTACK:        period_s = rate_period(regs.attack);
        DECAY_SUSTAIN: period_s = rate_period(regs.decay);
        default:       period_s = rate_period(regs.release_);
      endcase

      // Free-running 15-bit counter: a period lowered below the count runs on past 0x7FFF.
      rate_cnt_d = rate_cnt_q + 15'd1;
      if (rate_cnt_d == period_s) begin
        rate_cnt_d   = 15'd0;
        rate_event_s = 1'b1;
      end else begin
        rate_event_s = 1'b0;
      end

      if (rate_event_s) begin
        if (state_d == ATTACK) begin
          exp_cnt_d = 5'd0;
          if (env_q != 8'hFF) begin
            env_d = env_q + 8'd1;
          end else begin
            env_d = env_q;
          end
          if (env_d == 8'hFF) begin
            state_d = DECAY_SUSTAIN;
          end else begin
            state_d = ATTACK;
          end
        end else begin
          exp_cnt_d = exp_cnt_q + 5'd1;
          if (exp_cnt_d == exp_per_q) begin
            exp_cnt_d = 5'd0;
            if (!hold_zero_d && (env_q != 8'h00) &&
                ((state_d == RELEASE) || (env_q != {regs.sustain, regs.sustain}))) begin
              env_d = env_q - 8'd1;
            end else begin
              env_d = env_q;
            end
          end else begin
            exp_cnt_d = exp_cnt_q + 5'd1;
          end
        end
      end else begin
        exp_cnt_d = exp_cnt_q;
      end

      if (env_d != env_q) begin
        exp_per_d = exp_period_update(env_d, exp_per_q);
      end else begin
        exp_per_d = exp_per_q;
      end

      if ((state_d != ATTACK) && (env_d == 8'h00)) begin
        hold_zero_d = 1'b1;
      end else begin
        hold_zero_d = hold_zero_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RELEASE;
      env_q        <= 8'h00;
      rate_cnt_q   <= 15'd0;
      exp_cnt_q    <= 5'd0;
      exp_per_q    <= 5'd1;
      hold_zero_q  <= 1'b1;
      gate_prev_q  <= 1'b0;
      gate_armed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      env_q        <= env_d;
      rate_cnt_q   <= rate_cnt_d;
      exp_cnt_q    <= exp_cnt_d;
      exp_per_q    <= exp_per_d;
      hold_zero_q  <= hold_zero_d;
      gate_prev_q  <= gate_prev_d;
      gate_armed_q <= gate_armed_d;
    end
  end

endmodule

// File: tb/tb_sid_envelope.sv
// Directed bench for sid_envelope: per-cycle compare against an ADSR model plus literal checkpoints.
module tb_sid_envelope;
  import sid::*;

  logic clk;
  logic rst;
  sid_envelope_if bus ();

  sid_envelope dut (
    .clk      (clk),
    .rst      (rst),
    .phi2     (bus.phi2),
    .regs     (bus.regs),
    .envelope (bus.envelope)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  localparam int M_ATK = 0;
  localparam int M_DS  = 1;
  localparam int M_REL = 2;

  int rate_tab [16] = '{9, 32, 63, 95, 149, 220, 267, 313, 392, 977, 1954, 3126, 3907, 11720, 19532, 31251};

  int m_env, m_mode, m_hold, m_rate, m_expc, m_expp, m_gprev, m_armed;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: envelope 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_for(input int env, input int cur);
    if (env == 255) return 1;
    if (env == 93)  return 2;
    if (env == 54)  return 4;
    if (env == 26)  return 8;
    if (env == 14)  return 16;
    if (env == 6)   return 30;
    if (env == 0)   return 1;
    return cur;
  endfunction

  task automatic model_step();
    int per, old, g;
    bit rise, fall;
    g    = int'(bus.regs.gate);
    rise = (g == 1) && (m_gprev == 0) && (m_armed == 1);
    fall = (g == 0) && (m_gprev == 1);
    if (g == 0) m_armed = 1;
    m_gprev = g;
    if (rise) begin
      m_mode = M_ATK;
      m_hold = 0;
    end else if (fall) begin
      m_mode = M_REL;
    end
    if (m_mode == M_ATK)     per = rate_tab[bus.regs.attack];
    else if (m_mode == M_DS) per = rate_tab[bus.regs.decay];
    else                     per = rate_tab[bus.regs.release_];
    m_rate = (m_rate + 1) % 32768;
    old = m_env;
    if (m_rate == per) begin
      m_rate = 0;
      if (m_mode == M_ATK) begin
        m_expc = 0;
        if (m_env < 255) m_env++;
        if (m_env == 255) m_mode = M_DS;
      end else begin
        m_expc++;
        if (m_expc == m_expp) begin
          m_expc = 0;
          if (m_hold == 0 && m_env > 0 &&
              (m_mode == M_REL || m_env != 17 * int'(bus.regs.sustain)))
            m_env--;
        end
      end
    end
    if (m_env != old) m_expp = exp_for(m_env, m_expp);
    if (m_mode != M_ATK && m_env == 0) m_hold = 1;
  endtask

  // Reference model advances on the same edges the DUT samples.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_env = 0; m_mode = M_REL; m_hold = 1; m_rate = 0;
        m_expc = 0; m_expp = 1; m_gprev = 0; m_armed = 0;
      end else if (bus.phi2) begin
        model_step();
      end
    end
  end

  // Cycle-by-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) check("model", int'(bus.envelope), m_env);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit, envelope 0x%0h, required run end", bus.envelope);
    $fatal(1);
  end

  int phi2_cnt = 0;

  task automatic tick(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus.phi2 = 1'b1;
      @(posedge clk); #1;
      bus.phi2 = 1'b0;
      phi2_cnt++;
      for (int j = 0; j < gap; j++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.phi2 = i[0];
      @(posedge clk); #1;
      check_en = 1'b1;
    end
    rst = 1'b0;
    bus.phi2 = 1'b0;
  endtask

  task automatic run_until(input string name, input int target, input int budget, input int gap);
    int used;
    used = 0;
    while (int'(bus.envelope) != target && used < budget) begin
      tick(1, gap);
      used++;
    end
    check(name, int'(bus.envelope), target);
  endtask

  task automatic run_until_change(input int budget, input int gap, output int used);
    int start;
    start = int'(bus.envelope);
    used = 0;
    while (int'(bus.envelope) == start && used < budget) begin
      tick(1, gap);
      used++;
    end
  endtask

  int iv;

  initial begin
    rst = 1'b0;
    bus.phi2 = 1'b0;
    bus.regs = '{gate: 1'b0, attack: 4'd0, decay: 4'd0, sustain: 4'd8, release_: 4'd0};
    @(posedge clk); #1;

    // Reset and idle
    do_reset(6);
    check("reset_env", int'(bus.envelope), 0);
    tick(10000, 0);
    check("idle_10000", int'(bus.envelope), 0);

    // Attack from a clean rate phase
    do_reset(4);
    tick(9, 0);
    bus.regs.gate = 1'b1;
    tick(8, 0);
    check("attack_pre_first", int'(bus.envelope), 8'h00);
    tick(1, 0);
    check("attack_first", int'(bus.envelope), 8'h01);
    tick(2295 - 9, 0);
    check("attack_peak", int'(bus.envelope), 8'hFF);

    // Decay towards sustain 8
    tick(8, 0);
    check("decay_pre_first", int'(bus.envelope), 8'hFF);
    tick(1, 0);
    check("decay_first", int'(bus.envelope), 8'hFE);
    tick(1062, 0);
    check("sustain_reached", int'(bus.envelope), 8'h88);
    tick(500, 0);
    check("sustain_hold", int'(bus.envelope), 8'h88);

    // Release to zero, hold, then retrigger
    bus.regs.gate = 1'b0;
    run_until("release_zero", 0, 7000, 0);
    tick(300, 0);
    check("release_hold", int'(bus.envelope), 0);
    bus.regs.gate = 1'b1;
    run_until("retrigger", 1, 10, 0);

    // Early release at 0x40 with gaps between phi2 strobes
    run_until("attack_to_40", 8'h40, 700, 1);
    bus.regs.gate = 1'b0;
    run_until_change(60, 1, iv);
    check("early_rel_int1", iv, 36);
    check("early_rel_3f", int'(bus.envelope), 8'h3F);
    run_until_change(60, 1, iv);
    check("early_rel_int2", iv, 36);
    run_until_change(60, 2, iv);
    check("early_rel_int3", iv, 36);

    // Reset mid-attack with the gate held high
    tick(1, 0);
    bus.regs.gate = 1'b1;
    run_until("attack_to_80", 8'h80, 1300, 0);
    rst = 1'b1;
    bus.phi2 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.phi2 = 1'b0;
    check("midreset_env", int'(bus.envelope), 0);
    tick(100, 1);
    check("midreset_no_attack", int'(bus.envelope), 0);
    bus.regs.gate = 1'b0;
    tick(1, 0);
    bus.regs.gate = 1'b1;
    tick(10, 0);
    check("midreset_reattack", int'(bus.envelope), 1);

    // Lowering the period below the running count forces a full 15-bit wrap
    bus.regs = '{gate: 1'b0, attack: 4'd1, decay: 4'd0, sustain: 4'd8, release_: 4'd1};
    do_reset(2);
    tick(32, 0);
    bus.regs.gate = 1'b1;
    tick(31, 0);
    check("wrap_pre_first", int'(bus.envelope), 0);
    tick(1, 0);
    check("wrap_first", int'(bus.envelope), 1);
    tick(20, 0);
    bus.regs.attack = 4'd0;
    tick(32756, 0);
    check("wrap_pending", int'(bus.envelope), 1);
    tick(1, 0);
    check("wrap_match", int'(bus.envelope), 2);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
